countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 53 +++++
 rtl/countdown_timer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the MM:SS countdown timer
//
// Purpose: controller state encoding, BCD digit width and digit moduli used by
//          countdown_timer and bcd_down_digit.
// Ports:   none (package).

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DIGIT_W = 4;   // one BCD digit
  localparam int MOD_DEC = 10;  // ones digits and minute tens
  localparam int MOD_SEX = 6;   // seconds tens

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one down-counting BCD digit with borrow chain
//
// Purpose: holds one digit of the display. A borrow_in steps it down by one,
//          wrapping 0 -> MODULUS-1 and raising borrow_out for the next digit.
//          load (and rst) put the digit back to INIT_VAL.
// Ports:   clk, rst (async, active-high)
//          load       - reload INIT_VAL, overrides borrow_in
//          borrow_in  - decrement request from the less significant digit
//          digit      - registered digit value
//          borrow_out - decrement request to the more significant digit

module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MODULUS  = MOD_DEC,
  parameter int INIT_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] INIT = DIGIT_W'(INIT_VAL);
  localparam logic [DIGIT_W-1:0] TOP  = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = INIT;
    end else if (borrow_in) begin
      digit_d = (digit_q == '0) ? TOP : (digit_q - DIGIT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= INIT;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Borrow ripples only when this digit wraps.
  assign borrow_out = borrow_in & (digit_q == '0);
  assign digit      = digit_q;

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS countdown timer with run/pause/clear control
//
// Purpose: counts PRESET_MIN:PRESET_SEC down to 00:00 on 1 Hz ticks while
//          running; btn_start edges toggle run/pause, btn_clr reloads preset.
// Ports:   clk, rst (async, active-high)
//          tick      - one-cycle 1 Hz pulse
//          btn_start - level; each rising edge toggles run/pause
//          btn_clr   - level; back to IDLE with preset digits
//          min_tens, min_ones, sec_tens, sec_ones - registered BCD digits
//          running   - registered, high in RUN
//          done      - registered, high in DONE

module countdown_timer
  import timer_pkg::*;
#(
  parameter int PRESET_MIN = 1,
  parameter int PRESET_SEC = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_start,
  input  logic               btn_clr,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               done
);

  if (PRESET_MIN < 0 || PRESET_MIN > 99 || PRESET_SEC < 0 || PRESET_SEC > 59) begin : g_bad_preset
    $fatal(1, "countdown_timer: preset %0d:%0d out of range", PRESET_MIN, PRESET_SEC);
  end

  localparam int PRESET_MT = PRESET_MIN / 10;
  localparam int PRESET_MO = PRESET_MIN % 10;
  localparam int PRESET_ST = PRESET_SEC / 10;
  localparam int PRESET_SO = PRESET_SEC % 10;
  localparam bit PRESET_ZERO = (PRESET_MIN == 0) && (PRESET_SEC == 0);

  state_e state_q, state_d;
  logic   btn_start_d_q;
  logic   running_q, running_d;
  logic   done_q, done_d;

  logic   start_edge;
  logic   load;
  logic   dec;
  logic   at_one;
  logic   so_borrow, st_borrow, mo_borrow, mt_borrow;

  assign start_edge = btn_start & ~btn_start_d_q;
  assign load       = btn_clr;
  // A tick only counts in RUN and loses to clear and to a start edge.
  assign dec        = (state_q == ST_RUN) & tick & ~start_edge & ~btn_clr;
  assign at_one     = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

  bcd_down_digit #(.MODULUS(MOD_DEC), .INIT_VAL(PRESET_SO)) u_sec_ones (
    .clk(clk), .rst(rst), .load(load), .borrow_in(dec),
    .digit(sec_ones), .borrow_out(so_borrow)
  );

  bcd_down_digit #(.MODULUS(MOD_SEX), .INIT_VAL(PRESET_ST)) u_sec_tens (
    .clk(clk), .rst(rst), .load(load), .borrow_in(so_borrow),
    .digit(sec_tens), .borrow_out(st_borrow)
  );

  bcd_down_digit #(.MODULUS(MOD_DEC), .INIT_VAL(PRESET_MO)) u_min_ones (
    .clk(clk), .rst(rst), .load(load), .borrow_in(st_borrow),
    .digit(min_ones), .borrow_out(mo_borrow)
  );

  bcd_down_digit #(.MODULUS(MOD_DEC), .INIT_VAL(PRESET_MT)) u_min_tens (
    .clk(clk), .rst(rst), .load(load), .borrow_in(mo_borrow),
    .digit(min_tens), .borrow_out(mt_borrow)
  );

  always_comb begin
    state_d = state_q;
    if (btn_clr) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_edge) state_d = PRESET_ZERO ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (start_edge) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            // RUN never holds 00:00, so a borrow out of the top digit is
            // unreachable; treat it as terminal rather than let it wrap on.
            if (at_one || mt_borrow) state_d = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (start_edge) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign running_d = (state_d == ST_RUN);
  assign done_d    = (state_d == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      btn_start_d_q <= 1'b1;  // a button held through reset is not an edge
      running_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      btn_start_d_q <= btn_start;
      running_q     <= running_d;
      done_q        <= done_d;
    end
  end

  assign running = running_q;
  assign done    = done_q;

endmodule
